fifo_rd_packer: RTL and testbench



---
 rtl/fifo_rd_packer_if.sv | 54 +++++
 rtl/fifo_rd_packer.sv | 108 ++++++++++
 tb/tb_fifo_rd_packer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_if
//
// Bundles the FIFO read port, the flush request and the packed output stream
// of fifo_rd_packer. Clock and reset stay as plain ports on the module.
//
//   rdata     [DSIZE]        FIFO read data, valid while rempty=0
//   rempty                   FIFO empty flag
//   rinc                     FIFO pop strobe (one entry per rclk edge)
//   flush                    request to emit the current partial word
//   out_data  [DSIZE*LANES]  packed word, lane 0 = first-popped entry
//   out_keep  [LANES]        per-lane valid mask
//   out_valid                output word valid
//   out_ready                downstream accepts the word
//
// Modports:
//   master - the packer itself
//   slave  - the surrounding FIFO / sink environment
// -----------------------------------------------------------------------------
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int LANES = 4
);
    logic [DSIZE-1:0]       rdata;
    logic                   rempty;
    logic                   rinc;
    logic                   flush;
    logic [DSIZE*LANES-1:0] out_data;
    logic [LANES-1:0]       out_keep;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        input  rdata,
        input  rempty,
        input  flush,
        input  out_ready,
        output rinc,
        output out_data,
        output out_keep,
        output out_valid
    );

    modport slave (
        output rdata,
        output rempty,
        output flush,
        output out_ready,
        input  rinc,
        input  out_data,
        input  out_keep,
        input  out_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Read-side consumer of the async FIFO, clocked in the read domain. Pops
// DSIZE-bit entries and packs LANES consecutive entries into one wide word,
// lane 0 holding the first-popped entry. A flush emits a partially filled,
// zero-padded word so trailing data never stays stranded in the packer.
//
// Ports:
//   rclk     read-domain clock
//   rrst_n   asynchronous active-low reset
//   bus      fifo_rd_packer_if.master (FIFO read port, flush, output stream)
//
// Behaviour summary:
//   FILL : rinc = ~rempty; each pop writes lane idx and sets keep bit idx.
//          Filling the last lane, or a flush with data present (already held
//          or popped this very cycle), moves to HOLD.
//   HOLD : out_valid=1, no pops, word stable until out_ready; the accept
//          edge clears the accumulator and returns to FILL.
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int LANES = 4
) (
    input  logic               rclk,
    input  logic               rrst_n,
    fifo_rd_packer_if.master   bus
);
    localparam int WIDTH = DSIZE * LANES;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic [LANES-1:0]   kmask_reg;
    logic [IDX_W-1:0]   idx_reg;

    logic               pop;
    logic               last_lane;
    logic               go_hold;
    logic [LANES-1:0]   lane_wr;

    // rinc is combinational so the FIFO's asynchronously read rdata is
    // captured on the same edge that consumes the entry. Gating with rrst_n
    // keeps the FIFO from losing entries while the packer is held in reset.
    assign pop       = (state_reg == FILL) & ~bus.rempty & rrst_n;
    assign last_lane = (idx_reg == IDX_W'(LANES - 1));

    // A flush only closes the word if it would carry at least one entry,
    // counting the one being popped in this same cycle.
    assign go_hold   = (pop & last_lane) | (bus.flush & ((kmask_reg != '0) | pop));

    // One-hot lane write enables decoded from the lane index.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_wr
            assign lane_wr[gi] = pop & (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg <= FILL;
            acc_reg   <= '0;
            kmask_reg <= '0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_wr[i]) begin
                            acc_reg[i*DSIZE +: DSIZE] <= bus.rdata;
                            kmask_reg[i]              <= 1'b1;
                        end
                    end
                    if (pop) begin
                        idx_reg <= last_lane ? '0 : idx_reg + 1'b1;
                    end
                    if (go_hold) begin
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    // Clearing on accept keeps unwritten lanes of the next
                    // (possibly flushed) word zero-padded.
                    if (bus.out_ready) begin
                        state_reg <= FILL;
                        acc_reg   <= '0;
                        kmask_reg <= '0;
                        idx_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= FILL;
                end
            endcase
        end
    end

    assign bus.rinc      = pop;
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.out_data  = acc_reg;
    assign bus.out_keep  = kmask_reg;

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;
    localparam int D = 8;
    localparam int L = 4;
    localparam int W = D * L;

    logic rclk;
    logic rrst_n;

    fifo_rd_packer_if #(.DSIZE(D), .LANES(L)) bus ();

    fifo_rd_packer #(.DSIZE(D), .LANES(L)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_pass   = 0;

    // FIFO contents as seen by the packer (front = next entry to pop).
    logic [D-1:0] fifo_q[$];

    // Reference model: entries collected so far, and the word on offer.
    logic [D-1:0] m_cur[$];
    bit           m_hold;
    logic [W-1:0] m_data;
    logic [L-1:0] m_keep;

    // Log of words accepted at the output, as observed.
    logic [W-1:0] log_data[$];
    logic [L-1:0] log_keep[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Build the expected word from the collected entries: entry k in lane k,
    // remaining lanes zero, keep = k low ones.
    task automatic build_word();
        m_data = '0;
        m_keep = '0;
        for (int k = 0; k < m_cur.size(); k++) begin
            m_data = m_data | (W'(m_cur[k]) << (k * D));
            m_keep[k] = 1'b1;
        end
    endtask

    task automatic run_cycle(input bit fl, input bit rdy, input bit rst);
        bit exp_pop;
        @(negedge rclk);
        rrst_n        = rst ? 1'b0 : 1'b1;
        bus.flush     = fl;
        bus.out_ready = rdy;
        bus.rempty    = (fifo_q.size() == 0);
        bus.rdata     = (fifo_q.size() != 0) ? fifo_q[0] : D'($urandom);
        #1;
        if (rst) begin
            m_cur.delete();
            m_hold = 1'b0;
        end
        exp_pop = !rst && !m_hold && (fifo_q.size() != 0);
        check("rinc", bus.rinc, exp_pop);
        check("out_valid", bus.out_valid, m_hold);
        if (m_hold) begin
            check("out_data", bus.out_data, m_data);
            check("out_keep", bus.out_keep, m_keep);
        end
        if (!rst) begin
            if (m_hold) begin
                if (rdy) begin
                    log_data.push_back(bus.out_data);
                    log_keep.push_back(bus.out_keep);
                    $display("word %0d: data=%08h keep=%04b", log_data.size(), bus.out_data, bus.out_keep);
                    m_hold = 1'b0;
                    m_cur.delete();
                end
            end else begin
                if (exp_pop) m_cur.push_back(fifo_q.pop_front());
                if (m_cur.size() == L || (fl && m_cur.size() != 0)) begin
                    m_hold = 1'b1;
                    build_word();
                end
            end
        end
    endtask

    int base;

    initial begin
        m_hold        = 1'b0;
        rrst_n        = 1'b0;
        bus.rempty    = 1'b0;
        bus.rdata     = 8'h5A;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state with data offered on the FIFO port.
        repeat (3) @(negedge rclk);
        #1;
        check("rst_rinc", bus.rinc, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_keep", bus.out_keep, '0);
        check("rst_out_data", bus.out_data, '0);

        // Full word with an always-ready sink.
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        base = log_data.size();
        repeat (6) run_cycle(1'b0, 1'b1, 1'b0);
        check("full_count", log_data.size() - base, 1);
        if (log_data.size() > base) begin
            check("full_data", log_data[base], 32'h44332211);
            check("full_keep", log_keep[base], 4'hF);
        end

        // Backpressure: 8 entries, sink stalled while the first word is held.
        for (int k = 0; k < 8; k++) fifo_q.push_back(D'(8'hA0 + k));
        base = log_data.size();
        repeat (14) run_cycle(1'b0, 1'b0, 1'b0);
        check("bp_fifo_left", fifo_q.size(), 4);
        repeat (8) run_cycle(1'b0, 1'b1, 1'b0);
        check("bp_count", log_data.size() - base, 2);
        if (log_data.size() > base + 1) begin
            check("bp_word0", log_data[base], 32'hA3A2A1A0);
            check("bp_word1", log_data[base+1], 32'hA7A6A5A4);
        end

        // Flush on a partial word after the FIFO runs dry.
        fifo_q = '{8'hAA, 8'hBB};
        base = log_data.size();
        repeat (2) run_cycle(1'b0, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b0);
        repeat (2) run_cycle(1'b0, 1'b1, 1'b0);
        check("flush_count", log_data.size() - base, 1);
        if (log_data.size() > base) begin
            check("flush_data", log_data[base], 32'h0000BBAA);
            check("flush_keep", log_keep[base], 4'b0011);
        end

        // Flush in the same cycle as a pop, then flush with nothing held.
        fifo_q = '{8'hAA, 8'hBB};
        base = log_data.size();
        repeat (2) run_cycle(1'b0, 1'b1, 1'b0);
        fifo_q.push_back(8'hCC);
        run_cycle(1'b1, 1'b1, 1'b0);
        repeat (2) run_cycle(1'b0, 1'b1, 1'b0);
        repeat (4) run_cycle(1'b1, 1'b1, 1'b0);
        check("flushpop_count", log_data.size() - base, 1);
        if (log_data.size() > base) begin
            check("flushpop_data", log_data[base], 32'h00CCBBAA);
            check("flushpop_keep", log_keep[base], 4'b0111);
        end

        // Reset mid-word discards the partial word.
        fifo_q = '{8'h01, 8'h02};
        base = log_data.size();
        repeat (2) run_cycle(1'b0, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b1);
        fifo_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        repeat (7) run_cycle(1'b0, 1'b1, 1'b0);
        check("rstmid_count", log_data.size() - base, 1);
        if (log_data.size() > base) begin
            check("rstmid_data", log_data[base], 32'h40302010);
            check("rstmid_keep", log_keep[base], 4'hF);
        end

        // Randomized traffic: bursty FIFO, random flush, backpressure, resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(9) < 4 && fifo_q.size() < 16) fifo_q.push_back(D'($urandom));
            run_cycle($urandom_range(7) == 0, $urandom_range(9) < 7, $urandom_range(299) == 0);
        end
        repeat (12) run_cycle(1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
